// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module   : regfile_pkg
// Brief    : Shared register-file types and default widths for ID/WB stages.
// Revision : 1.0
// ============================================================================
package regfile_pkg;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } rf_state_e;

  localparam int RF_DATA_W = 32;
  localparam int RF_ADDR_W = 5;

endpackage
`default_nettype wire

// File: rtl/regfile_mp_if.sv
`default_nettype none
// ============================================================================
// Module   : regfile_mp_if
// Brief    : Read/write port bundle of the multi-port register file.
// Revision : 1.0
// ============================================================================
interface regfile_mp_if
  import regfile_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W
);

  logic              ready;
  logic [ADDR_W-1:0] rd_addr_a;
  logic [DATA_W-1:0] rd_data_a;
  logic [ADDR_W-1:0] rd_addr_b;
  logic [DATA_W-1:0] rd_data_b;
  logic              we0;
  logic [ADDR_W-1:0] waddr0;
  logic [DATA_W-1:0] wdata0;
  logic              we1;
  logic [ADDR_W-1:0] waddr1;
  logic [DATA_W-1:0] wdata1;
  logic [ADDR_W:0]   clr_count;

  modport master (
    input  ready, rd_data_a, rd_data_b, clr_count,
    output rd_addr_a, rd_addr_b, we0, waddr0, wdata0, we1, waddr1, wdata1
  );

  modport slave (
    output ready, rd_data_a, rd_data_b, clr_count,
    input  rd_addr_a, rd_addr_b, we0, waddr0, wdata0, we1, waddr1, wdata1
  );

endinterface
`default_nettype wire

// File: rtl/regfile_bypass.sv
`default_nettype none
// ============================================================================
// Module   : regfile_bypass
// Brief    : Per-read-port write-to-read forwarding select (port 1 wins).
// Revision : 1.0
// ============================================================================
module regfile_bypass
  import regfile_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W,
  parameter int BYPASS = 1
) (
  input  wire logic [ADDR_W-1:0] i_rd_addr,
  input  wire logic [DATA_W-1:0] i_mem_data,
  input  wire logic              i_we0,
  input  wire logic [ADDR_W-1:0] i_waddr0,
  input  wire logic [DATA_W-1:0] i_wdata0,
  input  wire logic              i_we1,
  input  wire logic [ADDR_W-1:0] i_waddr1,
  input  wire logic [DATA_W-1:0] i_wdata1,
  output logic      [DATA_W-1:0] o_rd_data
);

  logic              w_hit0;
  logic              w_hit1;
  logic [DATA_W-1:0] w_fwd;

  assign w_hit0 = i_we0 && (i_waddr0 == i_rd_addr);
  assign w_hit1 = i_we1 && (i_waddr1 == i_rd_addr);

  always_comb begin
    w_fwd = i_mem_data;
    if (w_hit0) w_fwd = i_wdata0;
    if (w_hit1) w_fwd = i_wdata1;
  end

  assign o_rd_data = (BYPASS != 0) ? w_fwd : i_mem_data;

endmodule
`default_nettype wire

// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
// Module   : regfile_mp
// Brief    : 2R/2W register file with bypass, zero register and clear engine.
// Revision : 1.0
// ============================================================================
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int                  DATA_W   = RF_DATA_W,
  parameter int                  ADDR_W   = RF_ADDR_W,
  parameter int                  ZERO_REG = 1,
  parameter int                  BYPASS   = 1,
  parameter logic [DATA_W-1:0]   INIT_VAL = '0
) (
  input  wire logic     clk,
  input  wire logic     rst,
  regfile_mp_if.slave   bus
);

  localparam int              DEPTH    = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W + 1)'(DEPTH - 1);
  localparam logic [0:0]      S_CLEAR  = ST_CLEAR;
  localparam logic [0:0]      S_RUN    = ST_RUN;

  logic [0:0]        r_state;
  logic              r_ready;
  logic [ADDR_W:0]   r_cnt;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_we0;
  logic              w_we1;
  logic [DATA_W-1:0] w_raw_a;
  logic [DATA_W-1:0] w_raw_b;
  logic [DATA_W-1:0] w_fwd_a;
  logic [DATA_W-1:0] w_fwd_b;
  logic              w_zero_a;
  logic              w_zero_b;

  // Counter runs one past the last index so it reads DEPTH once in RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_CLEAR;
      r_cnt   <= '0;
      r_ready <= 1'b0;
    end else if (r_state == S_CLEAR) begin
      r_cnt <= r_cnt + (ADDR_W + 1)'(1);
      if (r_cnt == LAST_IDX) begin
        r_state <= S_RUN;
        r_ready <= 1'b1;
      end
    end
  end

  assign w_we0 = bus.we0 && r_ready && !((ZERO_REG != 0) && (bus.waddr0 == '0));
  assign w_we1 = bus.we1 && r_ready && !((ZERO_REG != 0) && (bus.waddr1 == '0));

  // Port 1 is the later assignment, so it wins an address collision.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (r_state == S_CLEAR) begin
        r_mem[r_cnt[ADDR_W-1:0]] <= INIT_VAL;
      end else begin
        if (w_we0) r_mem[bus.waddr0] <= bus.wdata0;
        if (w_we1) r_mem[bus.waddr1] <= bus.wdata1;
      end
    end
  end

  assign w_raw_a = r_mem[bus.rd_addr_a];
  assign w_raw_b = r_mem[bus.rd_addr_b];

  regfile_bypass #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .BYPASS (BYPASS)
  ) u_bypass_a (
    .i_rd_addr  (bus.rd_addr_a),
    .i_mem_data (w_raw_a),
    .i_we0      (w_we0),
    .i_waddr0   (bus.waddr0),
    .i_wdata0   (bus.wdata0),
    .i_we1      (w_we1),
    .i_waddr1   (bus.waddr1),
    .i_wdata1   (bus.wdata1),
    .o_rd_data  (w_fwd_a)
  );

  regfile_bypass #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .BYPASS (BYPASS)
  ) u_bypass_b (
    .i_rd_addr  (bus.rd_addr_b),
    .i_mem_data (w_raw_b),
    .i_we0      (w_we0),
    .i_waddr0   (bus.waddr0),
    .i_wdata0   (bus.wdata0),
    .i_we1      (w_we1),
    .i_waddr1   (bus.waddr1),
    .i_wdata1   (bus.wdata1),
    .o_rd_data  (w_fwd_b)
  );

  // Entry 0 may hold INIT_VAL from the clear pass, so it is masked on read.
  assign w_zero_a = (ZERO_REG != 0) && (bus.rd_addr_a == '0);
  assign w_zero_b = (ZERO_REG != 0) && (bus.rd_addr_b == '0);

  assign bus.rd_data_a = (r_ready && !w_zero_a) ? w_fwd_a : '0;
  assign bus.rd_data_b = (r_ready && !w_zero_b) ? w_fwd_b : '0;
  assign bus.ready     = r_ready;
  assign bus.clr_count = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_mp
// Brief    : Scoreboard bench for two regfile_mp configurations.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_regfile_mp;

  localparam int A0 = 0, B0 = 1, R0 = 2, C0 = 3;
  localparam int A1 = 4, B1 = 5, R1 = 6, C1 = 7;
  localparam logic [31:0] INIT1 = 32'h0000_00C3;

  typedef struct {
    int          sig;
    logic [31:0] exp;
    string       name;
  } exp_t;

  logic clk = 1'b0;
  logic rst0;
  logic rst1;
  int   checks   = 0;
  int   failures = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  regfile_mp_if #(.DATA_W(32), .ADDR_W(5)) bus0 ();
  regfile_mp_if #(.DATA_W(32), .ADDR_W(3)) bus1 ();

  // dut0: bypass + zero register; dut1: no bypass, no zero register, nonzero init
  regfile_mp #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1), .INIT_VAL(32'h0))
    u_dut0 (.clk(clk), .rst(rst0), .bus(bus0));
  regfile_mp #(.DATA_W(32), .ADDR_W(3), .ZERO_REG(0), .BYPASS(0), .INIT_VAL(INIT1))
    u_dut1 (.clk(clk), .rst(rst1), .bus(bus1));

  task automatic expect_v(input int sig, input logic [31:0] v, input string nm);
    exp_t e;
    e.sig  = sig;
    e.exp  = v;
    e.name = nm;
    q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus0.rd_addr_a = '0; bus0.rd_addr_b = '0;
    bus0.we0 = 1'b0; bus0.waddr0 = '0; bus0.wdata0 = '0;
    bus0.we1 = 1'b0; bus0.waddr1 = '0; bus0.wdata1 = '0;
    bus1.rd_addr_a = '0; bus1.rd_addr_b = '0;
    bus1.we0 = 1'b0; bus1.waddr0 = '0; bus1.wdata0 = '0;
    bus1.we1 = 1'b0; bus1.waddr1 = '0; bus1.wdata1 = '0;
  endtask

  // Monitor: outputs are combinational, so every queued expectation is due this cycle
  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] act;
    while (q.size() > 0) begin
      e = q.pop_front();
      case (e.sig)
        A0:      act = bus0.rd_data_a;
        B0:      act = bus0.rd_data_b;
        R0:      act = 32'(bus0.ready);
        C0:      act = 32'(bus0.clr_count);
        A1:      act = bus1.rd_data_a;
        B1:      act = bus1.rd_data_b;
        R1:      act = 32'(bus1.ready);
        default: act = 32'(bus1.clr_count);
      endcase
      checks++;
      if (act !== e.exp) begin
        failures++;
        $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, act, e.exp);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst0 = 1'b1;
    rst1 = 1'b1;
    idle();
    tick();
    tick();
    rst0 = 1'b0;
    rst1 = 1'b0;

    // Clear pass from reset; stray writes must be ignored
    for (int i = 0; i < 32; i++) begin
      idle();
      bus0.we0 = 1'b1; bus0.waddr0 = 5'((i + 31) & 31); bus0.wdata0 = 32'hFFFF_FFFF;
      bus0.we1 = 1'b1; bus0.waddr1 = 5'((i + 30) & 31); bus0.wdata1 = 32'hEEEE_EEEE;
      bus0.rd_addr_a = 5'(i);
      bus1.rd_addr_a = 3'(i & 7);
      if (i < 8) begin
        bus1.we1 = 1'b1; bus1.waddr1 = 3'((i + 7) & 7); bus1.wdata1 = 32'h0000_0BAD;
      end
      expect_v(C0, 32'(i), "clear_count0");
      expect_v(R0, 32'd0, "clear_ready0");
      expect_v(A0, 32'd0, "clear_rd0");
      expect_v(C1, (i < 8) ? 32'(i) : 32'd8, "clear_count1");
      expect_v(R1, (i < 8) ? 32'd0 : 32'd1, "clear_ready1");
      expect_v(A1, (i < 8) ? 32'd0 : INIT1, "clear_rd1");
      tick();
    end
    idle();
    expect_v(R0, 32'd1, "done_ready0");
    expect_v(C0, 32'd32, "done_count0");
    expect_v(R1, 32'd1, "done_ready1");
    expect_v(C1, 32'd8, "done_count1");

    for (int i = 0; i < 32; i++) begin
      bus0.rd_addr_a = 5'(i);
      bus0.rd_addr_b = 5'(31 - i);
      bus1.rd_addr_a = 3'(i & 7);
      bus1.rd_addr_b = 3'(7 - (i & 7));
      expect_v(A0, 32'd0, "init_a0");
      expect_v(B0, 32'd0, "init_b0");
      expect_v(A1, INIT1, "init_a1");
      expect_v(B1, INIT1, "init_b1");
      tick();
    end

    // Reset reasserted mid-clear on dut0
    idle();
    rst0 = 1'b1;
    tick();
    rst0 = 1'b0;
    for (int i = 0; i <= 10; i++) begin
      expect_v(C0, 32'(i), "mid_count");
      if (i == 10) rst0 = 1'b1;
      tick();
    end
    rst0 = 1'b0;
    for (int j = 0; j < 32; j++) begin
      expect_v(C0, 32'(j), "restart_count");
      expect_v(R0, 32'd0, "restart_ready");
      tick();
    end
    expect_v(C0, 32'd32, "restart_done_count");
    expect_v(R0, 32'd1, "restart_done_ready");

    // C1: port-0 write with same-cycle bypass / no bypass on dut1
    idle();
    bus0.we0 = 1'b1; bus0.waddr0 = 5'd5; bus0.wdata0 = 32'hDEAD_BEEF;
    bus0.rd_addr_a = 5'd5; bus0.rd_addr_b = 5'd6;
    expect_v(A0, 32'hDEAD_BEEF, "wr_bypass_a0");
    expect_v(B0, 32'd0, "wr_other_b0");
    bus1.we1 = 1'b1; bus1.waddr1 = 3'd7; bus1.wdata1 = 32'h1234;
    bus1.rd_addr_a = 3'd7; bus1.rd_addr_b = 3'd0;
    expect_v(A1, INIT1, "nobyp_old_a1");
    expect_v(B1, INIT1, "nobyp_b1");
    tick();

    // C2
    idle();
    bus0.rd_addr_a = 5'd5; bus0.rd_addr_b = 5'd6;
    expect_v(A0, 32'hDEAD_BEEF, "readback_a0");
    expect_v(B0, 32'd0, "readback_b0");
    bus1.rd_addr_a = 3'd7; bus1.rd_addr_b = 3'd0;
    bus1.we0 = 1'b1; bus1.waddr0 = 3'd0; bus1.wdata0 = 32'hFFFF;
    expect_v(A1, 32'h1234, "nobyp_new_a1");
    expect_v(B1, INIT1, "nobyp_addr0_old_b1");
    tick();

    // C3: port-1 bypass on dut0; collision on dut1
    idle();
    bus0.we1 = 1'b1; bus0.waddr1 = 5'd7; bus0.wdata1 = 32'h1234;
    bus0.rd_addr_a = 5'd7; bus0.rd_addr_b = 5'd5;
    expect_v(A0, 32'h1234, "bypass_p1_a0");
    expect_v(B0, 32'hDEAD_BEEF, "hold_b0");
    bus1.we0 = 1'b1; bus1.waddr0 = 3'd2; bus1.wdata0 = 32'hAAAA;
    bus1.we1 = 1'b1; bus1.waddr1 = 3'd2; bus1.wdata1 = 32'h5555;
    bus1.rd_addr_a = 3'd0; bus1.rd_addr_b = 3'd2;
    expect_v(A1, 32'hFFFF, "addr0_writable_a1");
    expect_v(B1, INIT1, "collide_old_b1");
    tick();

    // C4
    idle();
    bus0.rd_addr_a = 5'd7; bus0.rd_addr_b = 5'd9;
    expect_v(A0, 32'h1234, "readback7_a0");
    expect_v(B0, 32'd0, "pre_collide_b0");
    bus1.rd_addr_a = 3'd2; bus1.rd_addr_b = 3'd7;
    expect_v(A1, 32'h5555, "collide_p1_wins_a1");
    expect_v(B1, 32'h1234, "hold_b1");
    tick();

    // C5: collision on dut0 with bypass
    idle();
    bus0.we0 = 1'b1; bus0.waddr0 = 5'd9; bus0.wdata0 = 32'hAAAA;
    bus0.we1 = 1'b1; bus0.waddr1 = 5'd9; bus0.wdata1 = 32'h5555;
    bus0.rd_addr_a = 5'd9; bus0.rd_addr_b = 5'd9;
    expect_v(A0, 32'h5555, "collide_bypass_a0");
    expect_v(B0, 32'h5555, "collide_bypass_b0");
    bus1.we0 = 1'b1; bus1.waddr0 = 3'd3; bus1.wdata0 = 32'h77;
    bus1.rd_addr_a = 3'd3; bus1.rd_addr_b = 3'd2;
    expect_v(A1, INIT1, "nobyp_p0_a1");
    expect_v(B1, 32'h5555, "hold2_b1");
    tick();

    // C6: split-address writes, bypass from port 0 while port 1 targets elsewhere
    idle();
    bus0.we0 = 1'b1; bus0.waddr0 = 5'd10; bus0.wdata0 = 32'h1111;
    bus0.we1 = 1'b1; bus0.waddr1 = 5'd11; bus0.wdata1 = 32'h2222;
    bus0.rd_addr_a = 5'd9; bus0.rd_addr_b = 5'd10;
    expect_v(A0, 32'h5555, "collide_stored_a0");
    expect_v(B0, 32'h1111, "bypass_p0_b0");
    bus1.rd_addr_a = 3'd3;
    expect_v(A1, 32'h77, "p0_stored_a1");
    tick();

    // C7
    idle();
    bus0.rd_addr_a = 5'd10; bus0.rd_addr_b = 5'd11;
    expect_v(A0, 32'h1111, "split_a0");
    expect_v(B0, 32'h2222, "split_b0");
    tick();

    // C8: zero register, both ports writing entry 0
    idle();
    bus0.we0 = 1'b1; bus0.waddr0 = 5'd0; bus0.wdata0 = 32'hFFFF;
    bus0.we1 = 1'b1; bus0.waddr1 = 5'd0; bus0.wdata1 = 32'hFFFF;
    bus0.rd_addr_a = 5'd0; bus0.rd_addr_b = 5'd11;
    expect_v(A0, 32'd0, "zero_same_a0");
    expect_v(B0, 32'h2222, "zero_other_b0");
    tick();

    // C9
    idle();
    expect_v(A0, 32'd0, "zero_after_a0");
    expect_v(B0, 32'd0, "zero_after_b0");
    expect_v(R0, 32'd1, "final_ready0");
    expect_v(C0, 32'd32, "final_count0");
    expect_v(R1, 32'd1, "final_ready1");
    expect_v(C1, 32'd8, "final_count1");
    tick();
    @(negedge clk);
    #1;

    checks++;
    if (bus0.ready !== 1'b1) begin
      failures++;
      $display("FAIL direct_ready0: got %0b", bus0.ready);
    end
    checks++;
    if (bus0.clr_count !== 6'd32) begin
      failures++;
      $display("FAIL direct_count0: got %0d", bus0.clr_count);
    end
    checks++;
    if (bus1.clr_count !== 4'd8) begin
      failures++;
      $display("FAIL direct_count1: got %0d", bus1.clr_count);
    end
    checks++;
    if (bus0.rd_data_a !== 32'd0) begin
      failures++;
      $display("FAIL direct_zero_a0: got 0x%08h", bus0.rd_data_a);
    end
    checks++;
    if (bus1.rd_data_a !== 32'hFFFF) begin
      failures++;
      $display("FAIL direct_addr0_a1: got 0x%08h", bus1.rd_data_a);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
